// File: rtl/lcb_rx_packet_framer_if.sv
// Bus bundle between the UARTRX byte source, the reply buffer RAM and the
// packer. The framer uses the slave view; the stimulus side uses master.
interface lcb_rx_packet_framer_if #(
  parameter int unsigned ADDR_W = 8
);
  // Request and byte input
  logic              iRQ;
  logic [7:0]        iData;
  logic              iVal;
  // Buffer write port
  logic [ADDR_W-1:0] oWrAddr;
  logic [7:0]        oWrData;
  logic              oWren;
  // Completion report
  logic              oDone;
  logic [ADDR_W-1:0] oLen;
  logic [2:0]        oStatus;
  logic              oBusy;

  modport master (
    output iRQ, iData, iVal,
    input  oWrAddr, oWrData, oWren, oDone, oLen, oStatus, oBusy
  );

  modport slave (
    input  iRQ, iData, iVal,
    output oWrAddr, oWrData, oWren, oDone, oLen, oStatus, oBusy
  );
endinterface

// File: rtl/lcb_rx_packet_framer.sv
// Reply packet framer: after a request it stores received bytes at
// consecutive buffer addresses, closes the packet on an inter-byte gap and
// reports length plus a status code (length and trailing checksum checks).
module lcb_rx_packet_framer #(
  parameter int unsigned EXP_BYTES  = 8,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned GAP_TICKS  = 800,
  parameter int unsigned RQ_TIMEOUT = 80000
) (
  input logic                   clk,
  input logic                   reset,
  lcb_rx_packet_framer_if.slave bus
);

  // One timer serves both the first-byte timeout and the inter-byte gap.
  localparam int unsigned TimerMax = (RQ_TIMEOUT > GAP_TICKS) ? RQ_TIMEOUT : GAP_TICKS;
  localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

  localparam logic [TimerW-1:0] RqLast  = TimerW'(RQ_TIMEOUT - 1);
  localparam logic [TimerW-1:0] GapLast = TimerW'(GAP_TICKS - 1);

  localparam logic [ADDR_W-1:0] ExpCnt = ADDR_W'(EXP_BYTES);
  localparam logic [ADDR_W-1:0] ChkIdx = ADDR_W'(EXP_BYTES - 1);
  localparam logic [ADDR_W-1:0] CntMax = {ADDR_W{1'b1}};

  localparam logic [2:0] StatOk      = 3'd0;
  localparam logic [2:0] StatNoReply = 3'd1;
  localparam logic [2:0] StatLong    = 3'd2;
  localparam logic [2:0] StatShort   = 3'd3;
  localparam logic [2:0] StatBadSum  = 3'd4;

  typedef enum logic [1:0] {
    StIdle,
    StWaitFirst,
    StRecv,
    StDone
  } state_e;

  state_e state_q, state_d;

  logic [ADDR_W-1:0] count_q, count_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        sum_q, sum_d;
  logic [7:0]        chk_q, chk_d;
  logic              long_q, long_d;

  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              done_q, done_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [2:0]        status_q, status_d;
  logic              busy_q, busy_d;

  logic              take;
  logic              finish;
  logic [2:0]        status_calc;

  // Status of the packet as it stands; priority NOREPLY > LONG > SHORT > BADSUM.
  always_comb begin
    status_calc = StatOk;
    if (count_q == '0) begin
      status_calc = StatNoReply;
    end else if (long_q) begin
      status_calc = StatLong;
    end else if (count_q < ExpCnt) begin
      status_calc = StatShort;
    end else if (chk_q != sum_q) begin
      status_calc = StatBadSum;
    end
  end

  // Next-state logic: FSM decode, then shared byte-accept and close actions.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    sum_d     = sum_q;
    chk_d     = chk_q;
    long_d    = long_q;
    wren_d    = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    len_d     = len_q;
    status_d  = status_q;
    busy_d    = busy_q;
    take      = 1'b0;
    finish    = 1'b0;

    unique case (state_q)
      StIdle: begin
        busy_d = 1'b0;
        // A byte arriving alongside the request is deliberately dropped.
        if (bus.iRQ) begin
          state_d = StWaitFirst;
          count_d = '0;
          timer_d = '0;
          sum_d   = '0;
          chk_d   = '0;
          long_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      StWaitFirst: begin
        // A byte wins over a coincident timeout.
        if (bus.iVal) begin
          take    = 1'b1;
          state_d = StRecv;
        end else if (timer_q == RqLast) begin
          finish  = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StRecv: begin
        // A byte on the gap-expiry cycle is accepted and restarts the gap.
        if (bus.iVal) begin
          take = 1'b1;
        end else if (timer_q == GapLast) begin
          finish  = 1'b1;
          state_d = StDone;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
    endcase

    if (take) begin
      timer_d = '0;
      if (count_q < ExpCnt) begin
        wren_d    = 1'b1;
        wr_addr_d = count_q;
        wr_data_d = bus.iData;
        if (count_q < ChkIdx) begin
          sum_d = sum_q + bus.iData;
        end else begin
          chk_d = bus.iData;
        end
      end else begin
        // Overlong reply: stop writing so the buffer beyond EXP_BYTES is untouched.
        long_d = 1'b1;
      end
      count_d = (count_q == CntMax) ? count_q : count_q + 1'b1;
    end

    if (finish) begin
      done_d   = 1'b1;
      len_d    = count_q;
      status_d = status_calc;
    end
  end

  // State and registered outputs; synchronous active-low reset aborts any packet.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      timer_q   <= '0;
      sum_q     <= '0;
      chk_q     <= '0;
      long_q    <= 1'b0;
      wren_q    <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      done_q    <= 1'b0;
      len_q     <= '0;
      status_q  <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      sum_q     <= sum_d;
      chk_q     <= chk_d;
      long_q    <= long_d;
      wren_q    <= wren_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      done_q    <= done_d;
      len_q     <= len_d;
      status_q  <= status_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.oWren   = wren_q;
  assign bus.oWrAddr = wr_addr_q;
  assign bus.oWrData = wr_data_q;
  assign bus.oDone   = done_q;
  assign bus.oLen    = len_q;
  assign bus.oStatus = status_q;
  assign bus.oBusy   = busy_q;

endmodule

// File: tb/tb_lcb_rx_packet_framer.sv
// Directed bench for lcb_rx_packet_framer with default parameters.
module tb_lcb_rx_packet_framer;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  lcb_rx_packet_framer_if #(.ADDR_W(8)) bus_if ();

  lcb_rx_packet_framer #(
    .EXP_BYTES (8),
    .ADDR_W    (8),
    .GAP_TICKS (800),
    .RQ_TIMEOUT(80000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Event log filled by the monitor; tests index it relative to a base.
  int wr_n = 0;
  int wr_addr_log[64];
  int wr_data_log[64];
  int last_wr_cyc = 0;
  int done_n = 0;
  int done_cyc = 0;
  int done_busy = 0;

  int arm_cyc = 0;
  logic [7:0] pkt[16];

  always @(posedge clk) cyc <= cyc + 1;

  // Sample outputs on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (bus_if.oWren) begin
      if (wr_n < 64) begin
        wr_addr_log[wr_n] <= int'(bus_if.oWrAddr);
        wr_data_log[wr_n] <= int'(bus_if.oWrData);
      end
      wr_n        <= wr_n + 1;
      last_wr_cyc <= cyc;
    end
    if (bus_if.oDone) begin
      done_n    <= done_n + 1;
      done_cyc  <= cyc;
      done_busy <= int'(bus_if.oBusy);
    end
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic arm(input bit with_val);
    bus_if.iRQ   = 1'b1;
    bus_if.iVal  = with_val;
    bus_if.iData = 8'hAA;
    tick();
    arm_cyc      = cyc;
    bus_if.iRQ   = 1'b0;
    bus_if.iVal  = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int spacing);
    bus_if.iData = b;
    bus_if.iVal  = 1'b1;
    tick();
    bus_if.iVal  = 1'b0;
    repeat (spacing - 1) tick();
  endtask

  task automatic send_pkt(input int n, input int spacing);
    for (int i = 0; i < n; i++) send_byte(pkt[i], spacing);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int start;
    int i;
    start = done_n;
    i = 0;
    while (done_n == start && i < budget) begin
      tick();
      i++;
    end
    check_eq({tag, "_done_seen"}, done_n - start, 1);
  endtask

  task automatic check_writes(input string tag, input int base, input int n);
    check_eq({tag, "_wr_count"}, wr_n - base, n);
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_wr_addr%0d", tag, i), wr_addr_log[base + i], i);
      check_eq($sformatf("%s_wr_data%0d", tag, i), wr_data_log[base + i], int'(pkt[i]));
    end
  endtask

  task automatic load_good();
    for (int i = 0; i < 7; i++) pkt[i] = 8'(i + 1);
    pkt[7] = 8'h1C;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_wren"},   int'(bus_if.oWren),   0);
    check_eq({tag, "_wraddr"}, int'(bus_if.oWrAddr), 0);
    check_eq({tag, "_wrdata"}, int'(bus_if.oWrData), 0);
    check_eq({tag, "_done"},   int'(bus_if.oDone),   0);
    check_eq({tag, "_len"},    int'(bus_if.oLen),    0);
    check_eq({tag, "_status"}, int'(bus_if.oStatus), 0);
    check_eq({tag, "_busy"},   int'(bus_if.oBusy),   0);
  endtask

  initial begin
    int base;
    int dbase;

    bus_if.iRQ   = 1'b0;
    bus_if.iVal  = 1'b0;
    bus_if.iData = 8'h00;
    reset = 1'b0;
    repeat (3) tick();
    check_outputs_zero("reset");
    reset = 1'b1;
    tick();

    // Good packet, bytes 160 clocks apart.
    load_good();
    base = wr_n;
    arm(1'b0);
    check_eq("good_busy_armed", int'(bus_if.oBusy), 1);
    send_pkt(8, 160);
    wait_done("good", 1000);
    check_writes("good", base, 8);
    check_eq("good_gap", done_cyc - last_wr_cyc, 800);
    check_eq("good_busy_at_done", done_busy, 1);
    check_eq("good_busy_after", int'(bus_if.oBusy), 0);
    check_eq("good_done_pulse", int'(bus_if.oDone), 0);
    check_eq("good_len", int'(bus_if.oLen), 8);
    check_eq("good_status", int'(bus_if.oStatus), 0);
    repeat (5) tick();

    // Bad checksum.
    pkt[7] = 8'h1D;
    base = wr_n;
    arm(1'b0);
    send_pkt(8, 20);
    wait_done("badsum", 1000);
    check_writes("badsum", base, 8);
    check_eq("badsum_len", int'(bus_if.oLen), 8);
    check_eq("badsum_status", int'(bus_if.oStatus), 4);
    repeat (5) tick();

    // Short packet; a byte coincident with the request is dropped.
    load_good();
    base = wr_n;
    arm(1'b1);
    send_pkt(5, 20);
    wait_done("short", 1000);
    check_writes("short", base, 5);
    check_eq("short_len", int'(bus_if.oLen), 5);
    check_eq("short_status", int'(bus_if.oStatus), 3);
    repeat (5) tick();

    // Long packet: only the first eight bytes are written.
    for (int i = 0; i < 10; i++) pkt[i] = 8'(8'h30 + i);
    base = wr_n;
    arm(1'b0);
    send_pkt(10, 20);
    wait_done("long", 1000);
    check_writes("long", base, 8);
    check_eq("long_len", int'(bus_if.oLen), 10);
    check_eq("long_status", int'(bus_if.oStatus), 2);
    check_eq("long_addr_hold", int'(bus_if.oWrAddr), 7);
    repeat (5) tick();

    // No reply; idle bytes before the request are ignored.
    base = wr_n;
    send_byte(8'h55, 5);
    send_byte(8'h66, 5);
    check_eq("idle_busy", int'(bus_if.oBusy), 0);
    arm(1'b0);
    wait_done("noreply", 80100);
    check_eq("noreply_latency", done_cyc - arm_cyc, 80000);
    check_eq("noreply_writes", wr_n - base, 0);
    check_eq("noreply_len", int'(bus_if.oLen), 0);
    check_eq("noreply_status", int'(bus_if.oStatus), 1);
    repeat (5) tick();

    // Reset mid-packet aborts without a done pulse.
    load_good();
    base  = wr_n;
    dbase = done_n;
    arm(1'b0);
    send_pkt(3, 10);
    reset = 1'b0;
    tick();
    check_outputs_zero("midreset");
    reset = 1'b1;
    repeat (900) tick();
    check_eq("midreset_writes", wr_n - base, 3);
    check_eq("midreset_no_done", done_n - dbase, 0);

    base = wr_n;
    arm(1'b0);
    send_pkt(8, 10);
    wait_done("rearm", 1000);
    check_writes("rearm", base, 8);
    check_eq("rearm_len", int'(bus_if.oLen), 8);
    check_eq("rearm_status", int'(bus_if.oStatus), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lcb_rx_packet_framer.md
Name: lcb_rx_packet_framer

Overview:
Packet framer between a UARTRX byte receiver and a reply buffer RAM. It serves the MCM and LCB links and runs on the 80 MHz system clock. After a request strobe from the M8 frame former, it captures the reply bytes into consecutive buffer addresses. It closes the packet on an inter-byte gap, checks the length and trailing checksum, then issues a one-cycle done pulse with a status code to the packer.

Parameters:
EXP_BYTES, 8, expected reply length in bytes including the checksum byte (range 2..255)
ADDR_W, 8, buffer address width
GAP_TICKS, 800, idle clocks after the last byte that close a packet (10 us at 80 MHz)
RQ_TIMEOUT, 80000, clocks to wait for the first byte after a request (1 ms)

Ports:
clk  in  1  system clock, 80 MHz
reset  in  1  synchronous, active-low reset
iRQ  in  1  request strobe from the frame former; arms the framer
iData  in  8  received byte from UARTRX
iVal  in  1  one-cycle valid for iData
oWrAddr  out  ADDR_W  buffer write address
oWrData  out  8  buffer write data
oWren  out  1  buffer write enable
oDone  out  1  one-cycle packet-complete pulse
oLen  out  ADDR_W  number of bytes received in the last packet, saturating at 2^ADDR_W-1
oStatus  out  3  0 OK, 1 NOREPLY, 2 LONG, 3 SHORT, 4 BADSUM
oBusy  out  1  high from arming until the cycle after oDone

Behaviour:
- Reset (reset==0 sampled on a rising clk edge):
  - state goes to IDLE.
  - Every output is 0.
  - All counters, the sum register and the flags clear.
  - Reset applied mid-packet aborts the packet with no oDone pulse.
- States: IDLE, WAIT_FIRST, RECV, DONE.
- IDLE:
  - oBusy=0.
  - iVal is ignored.
  - iRQ=1 -> WAIT_FIRST. Byte count, timer, sum and LONG flag clear.
  - If iRQ and iVal arrive in the same cycle, the byte is ignored.
- WAIT_FIRST:
  - oBusy=1; the timer increments every clock.
  - iVal=1 -> byte is written at address 0, count=1, gap timer=0, go to RECV.
  - Timer reaches RQ_TIMEOUT-1 with no iVal -> DONE with NOREPLY.
  - iVal wins if it coincides with the timeout.
- RECV:
  - On each iVal with count<EXP_BYTES: write the byte at address count, count+1, gap timer=0.
  - On iVal with count>=EXP_BYTES: no write, set the LONG flag, count still increments (saturating), gap timer=0.
  - No iVal: the gap timer increments; reaching GAP_TICKS-1 -> DONE.
  - iVal coinciding with the gap expiry is accepted and the timer restarts.
- Write port:
  - oWren, oWrAddr and oWrData are registered; oWren is high exactly one clock, the cycle after the accepted iVal.
  - oWrAddr holds its last value when oWren=0.
- Checksum:
  - An 8-bit modulo-256 sum is accumulated over bytes at indices 0..EXP_BYTES-2.
  - The byte at index EXP_BYTES-1 is compared against that sum.
- DONE (one cycle):
  - oDone=1; oLen and oStatus are updated; next state is IDLE.
  - oBusy drops in the following cycle.
  - oLen/oStatus hold until the next DONE.
- Status priority: NOREPLY (count==0) > LONG (flag set) > SHORT (count<EXP_BYTES) > BADSUM (sum mismatch) > OK.
- iRQ while not in IDLE is ignored; there is no re-arm or restart.
- The last oWren precedes oDone by at least GAP_TICKS-1 clocks, so the buffer is stable when the packer starts reading.

Test Plan:
- Defaults, iRQ, then 8 bytes 01 02 03 04 05 06 07 1C spaced 160 clocks apart -> 8 oWren pulses at addresses 0..7 with matching data; oDone ~800 clocks after the last byte; oLen=8, oStatus=0.
- Same packet with the last byte 1D -> oLen=8, oStatus=4 (BADSUM).
- iRQ, then 5 bytes -> 5 writes; oLen=5, oStatus=3 (SHORT).
- iRQ, then 10 bytes -> 8 writes only, addresses 0..7; oLen=10, oStatus=2 (LONG).
- iRQ with no bytes -> oDone exactly 80000 clocks after arming; oLen=0, oStatus=1; no oWren. iVal pulses in IDLE before the iRQ produce no writes.
- Reset asserted for 1 clock after 3 bytes of a packet -> all outputs 0, no oDone. A new iRQ plus 8 good bytes then gives oStatus=0, oLen=8, with writes starting at address 0.
